// File: rtl/spram_fb_arb.sv
// Framebuffer over N_BANKS single-port 16Kx16 SPRAMs split into pixel lanes.
// Arbitrates display reads, producer writes and a hardware clear engine.
module spram_fb_arb #(
  parameter int DATA_W  = 8,
  parameter int N_BANKS = 3,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int LANES = 16 / DATA_W;
  localparam int MW    = DATA_W / 4;
  localparam int LMASK = (1 << MW) - 1;
  localparam int SLOTS = N_BANKS * LANES;
  localparam logic [13:0] LAST = 14'h3fff;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [13:0]       cnt;
  logic [DATA_W-1:0] clr_val;

  logic [31:0] rd_sel;
  logic [31:0] wr_sel;
  logic [1:0]  rd_bank;
  logic [1:0]  rd_lane;
  logic [1:0]  wr_bank;
  logic [1:0]  wr_lane;
  logic        rd_inr;
  logic        wr_inr;

  assign rd_sel  = 32'(rd_addr[ADDR_W-1:14]);
  assign wr_sel  = 32'(wr_addr[ADDR_W-1:14]);
  assign rd_bank = 2'(rd_sel / 32'(LANES));
  assign rd_lane = 2'(rd_sel % 32'(LANES));
  assign wr_bank = 2'(wr_sel / 32'(LANES));
  assign wr_lane = 2'(wr_sel % 32'(LANES));
  assign rd_inr  = rd_sel < 32'(SLOTS);
  assign wr_inr  = wr_sel < 32'(SLOTS);

  logic do_rd;
  logic do_clr;
  logic do_wr;

  assign do_rd    = rd_req;
  assign do_clr   = (state == CLEAR) && !rd_req;
  assign wr_ready = reset_n && !rd_req && !clr_busy;
  assign do_wr    = wr_valid && wr_ready;

  logic [13:0]        mem_addr;
  logic [15:0]        mem_din;
  logic [3:0]         mem_mask;
  logic [N_BANKS-1:0] bank_we;

  always_comb begin
    mem_addr = wr_addr[13:0];
    mem_din  = {LANES{wr_data}};
    mem_mask = 4'(LMASK << (32'(wr_lane) * 32'(MW)));
    bank_we  = '0;
    unique case (1'b1)
      do_rd: begin
        mem_addr = rd_addr[13:0];
      end
      do_clr: begin
        mem_addr = cnt;
        mem_din  = {LANES{clr_val}};
        mem_mask = 4'hf;
        bank_we  = '1;
      end
      do_wr: begin
        // Out-of-range writes hit no bank and vanish.
        for (int b = 0; b < N_BANKS; b++)
          bank_we[b] = wr_inr && (32'(wr_bank) == 32'(b));
      end
      default: ;
    endcase
  end

  logic [15:0] dout [N_BANKS];

`ifdef DEBUG
  logic [15:0] mem [N_BANKS][16384];

  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_we[b]) begin
        for (int n = 0; n < 4; n++)
          if (mem_mask[n])
            mem[b][mem_addr][n*4 +: 4] <= mem_din[n*4 +: 4];
      end else begin
        dout[b] <= mem[b][mem_addr];
      end
    end
  end
`elsif SYNTHESIS
  for (genvar b = 0; b < N_BANKS; b++) begin : g_spram
    SB_SPRAM256KA u_spram (
      .ADDRESS    (mem_addr),
      .DATAIN     (mem_din),
      .MASKWREN   (mem_mask),
      .WREN       (bank_we[b]),
      .CHIPSELECT (1'b1),
      .CLOCK      (clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (dout[b])
    );
  end
`else
  logic [15:0] mem [N_BANKS][16384];

  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_we[b]) begin
        for (int n = 0; n < 4; n++)
          if (mem_mask[n])
            mem[b][mem_addr][n*4 +: 4] <= mem_din[n*4 +: 4];
      end else begin
        dout[b] <= mem[b][mem_addr];
      end
    end
  end
`endif

  logic       rd_v1;
  logic       rd_inr1;
  logic [1:0] rd_bank1;
  logic [1:0] rd_lane1;
  logic [15:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < N_BANKS; b++)
      if (32'(rd_bank1) == 32'(b))
        rd_word = dout[b];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1    <= 1'b0;
      rd_inr1  <= 1'b0;
      rd_bank1 <= '0;
      rd_lane1 <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_v1    <= rd_req;
      rd_inr1  <= rd_inr;
      rd_bank1 <= rd_bank;
      rd_lane1 <= rd_lane;
      rd_valid <= rd_v1;
      if (rd_v1)
        rd_data <= rd_inr1 ?
          DATA_W'(rd_word >> (32'(rd_lane1) * 32'(DATA_W))) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_val  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            clr_val  <= clr_value;
            state    <= CLEAR;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // A read steals the cycle; the clear just waits.
          if (!rd_req) begin
            if (cnt == LAST) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 14'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
